// File: rtl/dw_pkg.sv
// Shared definitions for the depthwise datapath: the per-lane register-array command
// encoding used by the buffer sequencer and by dw_reg_array.
package dw_pkg;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_IB = 2'b00;  // load from input-buffer read data
    localparam cmd_t CMD_SF = 2'b01;  // shift toward lane 0, push displaced pixel
    localparam cmd_t CMD_IF = 2'b10;  // reload from reuse FIFO head (no pop)
    localparam cmd_t CMD_NE = 2'b11;  // hold

    function automatic logic cmd_active(input cmd_t c);
        return c != CMD_NE;
    endfunction

endpackage

// File: rtl/reuse_fifo.sv
// Single-clock first-word-fall-through FIFO holding pixels displaced by row shifts.
// Push and pop in the same cycle are both honoured, even when full.
module reuse_fifo #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [LW-1:0] level,
    output logic          ovf_pulse,
    output logic          udf_pulse
);

    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          empty;
    logic          full;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_LEVEL);
    assign pop_ok  = pop && !empty;
    // A simultaneous pop frees the slot this push needs, so full does not block it.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    assign dout      = mem[rd_ptr];
    assign level     = count;
    assign ovf_pulse = push && full && !pop_ok;
    assign udf_pulse = pop && empty;

endmodule

// File: rtl/dw_reg_array.sv
// Per-output-row pixel register array feeding the depthwise PE array; executes
// per-lane IB/SF/IF/NE commands and replays shifted-out pixels via reuse FIFOs.
module dw_reg_array
    import dw_pkg::*;
#(
    parameter int POY        = 3,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2*POY-1:0]  reg_array_cmd,
    input  logic              fifo_read,
    input  logic [POY*DW-1:0] buf_data,
    output logic [POY*DW-1:0] pix_out,
    output logic              pix_valid,
    output logic [LW-1:0]     fifo_level,
    output logic              fifo_ovf,
    output logic              fifo_udf
);

    logic [DW-1:0]  lane_q    [POY];
    logic [DW-1:0]  lane_d    [POY];
    logic [DW-1:0]  shift_src [POY];
    logic [DW-1:0]  head      [POY];
    logic [LW-1:0]  lvl       [POY];
    logic [POY-1:0] push;
    logic [POY-1:0] ovf_p;
    logic [POY-1:0] udf_p;
    logic [POY-1:0] if_empty;
    logic           any_active;

    // Shift source: the next lane up, with the top lane fed from fresh buffer data.
    for (genvar i = 0; i < POY; i++) begin : g_lane
        if (i < POY - 1) begin : g_mid
            assign shift_src[i] = lane_q[i+1];
        end else begin : g_top
            assign shift_src[i] = buf_data[DW*i +: DW];
        end

        reuse_fifo #(
            .DW         (DW),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .pop       (fifo_read),
            .din       (lane_q[i]),
            .dout      (head[i]),
            .level     (lvl[i]),
            .ovf_pulse (ovf_p[i]),
            .udf_pulse (udf_p[i])
        );

        assign pix_out[DW*i +: DW] = lane_q[i];
    end

    always_comb begin
        any_active = 1'b0;
        push       = '0;
        if_empty   = '0;
        for (int i = 0; i < POY; i++) begin
            lane_d[i] = lane_q[i];
            if (cmd_active(reg_array_cmd[2*i +: 2])) any_active = 1'b1;
            case (reg_array_cmd[2*i +: 2])
                CMD_IB: lane_d[i] = buf_data[DW*i +: DW];
                CMD_SF: begin
                    lane_d[i] = shift_src[i];
                    push[i]   = 1'b1;
                end
                CMD_IF: begin
                    // An empty FIFO has no valid head: hold and flag underflow.
                    if (lvl[i] == '0) if_empty[i] = 1'b1;
                    else              lane_d[i]   = head[i];
                end
                default: lane_d[i] = lane_q[i];
            endcase
        end
    end

    // pix_valid qualifies pix_out for exactly the cycle after any non-NE command;
    // there is no ready, the PE array must consume every valid cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < POY; i++) lane_q[i] <= '0;
            pix_valid <= 1'b0;
            fifo_ovf  <= 1'b0;
            fifo_udf  <= 1'b0;
        end else begin
            for (int i = 0; i < POY; i++) lane_q[i] <= lane_d[i];
            pix_valid <= any_active;
            fifo_ovf  <= fifo_ovf | (|ovf_p);
            fifo_udf  <= fifo_udf | (|udf_p) | (|if_empty);
        end
    end

    assign fifo_level = lvl[0];

endmodule

// File: doc/dw_reg_array.md
Name: dw_reg_array

Overview:
- Per-output-row pixel register array between the input-buffer interface sequencer and the depthwise PE array (dwpe).
- Executes the per-lane 2-bit commands issued each cycle by the sequencer: load from buffer read data, shift rows, reload from the reuse FIFOs, or hold.
- Presents POY pixels per cycle to the dwpe.
- Holds one reuse FIFO per lane so that pixels displaced by shifts are replayed on the next column without re-reading the buffer.

Parameters:
- POY, 3, number of lanes (output rows processed in parallel).
- DW, 8, pixel width in bits.
- FIFO_DEPTH, 16, entries per lane reuse FIFO; power of two, at least 4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- reg_array_cmd  in  2*POY  per-lane command; lane i is bits [2i+1:2i]. Encoding: 00 IB, 01 SF, 10 IF, 11 NE.
- fifo_read  in  1  single-cycle pulse; pops the head of every lane FIFO.
- buf_data  in  POY*DW  input-buffer read data; lane i is bits [DW*i +: DW].
- pix_out  out  POY*DW  lane registers, same packing as buf_data.
- pix_valid  out  1  high for one cycle following any cycle in which some lane had cmd IB, SF or IF.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy of lane 0 FIFO (all lanes move in lockstep).
- fifo_ovf  out  1  sticky; a push was attempted on a full FIFO.
- fifo_udf  out  1  sticky; a pop or IF read was attempted on an empty FIFO.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert at the source): all lane registers 0, pix_out 0, pix_valid 0, FIFOs emptied, fifo_level 0, fifo_ovf 0, fifo_udf 0. Assertion mid-operation discards all FIFO contents immediately.
- Latency: the command applied in cycle t takes effect on pix_out at the clock edge ending cycle t. pix_valid is registered alongside the data.
- Per-lane command decode for lane i, on the clock edge:
  - IB: reg[i] <= buf_data[i].
  - SF: push the old reg[i] into fifo[i]. For i < POY-1, reg[i] <= reg[i+1] (old value). For lane POY-1, reg[i] <= buf_data[POY-1].
  - IF: reg[i] <= head of fifo[i]. This does not pop by itself; popping happens only via fifo_read.
  - NE: hold reg[i]; no push.
- Commands are independent per lane. A mixed vector such as {IB, IF, IF} is legal and common.
- fifo_read:
  - Pops every lane FIFO in the same cycle.
  - A push and a pop in the same cycle are both performed; occupancy is unchanged; this is legal even when the FIFO is full.
  - IF together with fifo_read in the same cycle returns the pre-pop head.
- FIFO is first-word-fall-through: the head is valid combinationally whenever occupancy > 0.
- Full FIFO with push and no pop: the push is dropped, data is not written, and fifo_ovf is set.
- Empty FIFO on pop or IF: pointers are unchanged, a lane in IF holds its old value, and fifo_udf is set.
- Sticky error flags clear only on rst.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Occupancy is computed one bit wider.
- There is no backpressure. The sequencer guarantees at most one pop per pushed pixel.

Decomposition:
- Package dw_pkg:
  - typedef cmd_t (2-bit).
  - constants CMD_IB=2'b00, CMD_SF=2'b01, CMD_IF=2'b10, CMD_NE=2'b11.
  - the same package is imported by the sequencer.
- Sub-module reuse_fifo:
  - Single-clock FWFT FIFO, parameters DW and FIFO_DEPTH.
  - Ports: push, pop, din, dout, level, ovf_pulse, udf_pulse.
  - Instantiated POY times via generate.
- The top level contains only the lane muxes, the valid register and the sticky flags.

Test Plan:
- IB load: after reset apply cmd={IB,IB,IB} with buf_data lanes {0x30,0x20,0x10} (lane2..0), then NE. Required: next cycle pix_out = {0x30,0x20,0x10}, pix_valid=1 for exactly one cycle, fifo_level=0.
- Shift: starting from {0x30,0x20,0x10}, apply SF on all lanes with buf_data lane2=0x40. Required: pix_out={0x40,0x30,0x20}, fifo_level=1, fifo0 head=0x10, fifo1 head=0x20.
- Reuse: after two SF steps, pulse fifo_read together with cmd={IB,IF,IF} and buf_data lane2=0x77. Required: lane0/1 get the original first-pushed heads, lane2=0x77, fifo_level decrements by 1.
- Full boundary: push FIFO_DEPTH+1 times with no pop. Required: fifo_level=16, fifo_ovf=1, and the 17th value never appears at the head after 16 pops. Then SF together with fifo_read while full: level stays 16 and fifo_ovf does not newly fire.
- Underflow: IF on all lanes with empty FIFOs. Required: pix_out unchanged, fifo_udf=1 and stays 1 through later traffic until rst.
- Async reset mid-stream: assert rst between edges with level=5. Required: pix_out=0, fifo_level=0 and flags=0 immediately, without waiting for a clock edge. First IB after release loads normally.
